uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Standalone oversampling UART receiver that turns an asynchronous serial line into parallel bytes with a one-cycle completion strobe. It is the receive end that pairs with the existing `uart` transmitter path. It also replaces loopback-only reception when the serial source is external, such as another board or a host. It samples each bit near its centre with a 2-of-3 majority vote and reports framing errors, plus parity errors when parity is compiled in.

## Interface
Parameters:
- `CLK_FREQ`, 1_000_000: clock frequency in Hz.
- `BAUD`, 9600: line bit rate.
- `OVERSAMPLE`, 16: ticks per bit; must be even and ≥ 8.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  serial line; idles high; asynchronous to `clk`.
- `rxout`  out  8  last received byte; held until the next good byte.
- `rxdone`  out  1  one-cycle pulse when `rxout` has been updated with a good byte.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `parity_err`  out  1  one-cycle pulse on a parity mismatch; exists only with `UART_RX_PARITY_EN`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Input conditioning:
  - `rx` passes through a 2-flop synchronizer (reset value 1).
  - All logic uses the synchronized value `rx_s`.
- Tick generator:
  - `DIV = CLK_FREQ / (BAUD*OVERSAMPLE)`, integer, truncated; minimum 1.
  - Free-running while not in IDLE; cleared on entry to START.
  - A tick is a one-cycle pulse every `DIV` clocks.
- Per-bit tick counter `tcnt`, 0..OVERSAMPLE-1:
  - Samples `rx_s` at `OVERSAMPLE/2-1`, `OVERSAMPLE/2`, `OVERSAMPLE/2+1`.
  - The bit value is the majority of those 3 samples.
  - The bit period ends at `tcnt == OVERSAMPLE-1`.
- States:
  - IDLE: go to START on `rx_s == 0`.
  - START: at the mid-bit vote:
    - vote = 1: the event is a glitch; return to IDLE with no output activity.
    - vote = 0: continue; go to DATA at the end of the bit.
  - DATA:
    - 8 bits, LSB first, shifted into a shift register.
    - Bit counter 0..7; after bit 7 go to PARITY if enabled, otherwise STOP.
  - PARITY (only if enabled): the voted bit is compared against even parity of the data.
  - STOP: at the mid-bit vote:
    - vote = 1, no parity error: load `rxout`, pulse `rxdone`, go to IDLE.
    - vote = 1, parity error: pulse `parity_err` only; `rxout` is unchanged; go to IDLE.
    - vote = 0: pulse `frame_err`; `rxout` is unchanged; go to BREAK.
  - BREAK: wait for `rx_s == 1`, then go to IDLE. This prevents a held-low line from re-triggering continuously.
- Back-to-back frames: returning to IDLE at mid-stop bit allows a new start edge to be accepted half a bit early, which tolerates up to ~3% baud mismatch.

## Timing
- Reset values:
  - `rxout` = 0x00.
  - `rxdone`, `frame_err`, `parity_err`, `busy` = 0.
  - State = IDLE; synchronizer outputs = 1.
- Reset asserted mid-frame aborts immediately: no strobes, `rxout` is held at 0x00.
- With `DIV = 1` and `OVERSAMPLE = 16`:
  - Bit period = 16 clocks.
  - `rxdone` rises 2 (sync) + 9·16 + 8 + 1 = 155 clocks (±1) after the falling edge of `rx`, for 8N1.
  - With parity, add 16 clocks.
- All strobes are registered, exactly one cycle wide, and mutually exclusive.
- `rxout` changes in the same cycle that `rxdone` is high.
- `busy` rises 3 clocks after the falling edge of `rx`, and falls in the cycle after `rxdone`/`frame_err`/`parity_err`, or after glitch rejection.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1.
  - The PARITY state and the `parity_err` port exist.
- `UART_RX_PARITY_EN` undefined:
  - Frame is 8N1.
  - No PARITY state and no `parity_err` port.
- All other behaviour is identical in both builds.

## Structure
- Package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - `UART_DATA_W = 8`;
  - the `uart_div()` constant function used for `DIV`.
- Sub-module `uart_baud_tick`:
  - parameter `DIV`;
  - inputs `clk`, `rst`, `clr`;
  - output `tick`.
  - Shared with future transmitter rework.
- Top level holds the synchronizer, the FSM, the shift register and the output registers.

## Test plan
Bench parameters: `CLK_FREQ = 1_000_000`, `BAUD = 62_500`, so `DIV = 1` and one bit = 16 clocks.
- Byte 0xA5 sent 8N1 → `rxdone` pulse at 155±1 clocks after the falling edge, `rxout` = 0xA5, no error strobes.
- 10 random bytes in the range 10..200 sent back-to-back, with the stop bit only 8 clocks long → all 10 received in order, 10 `rxdone` pulses.
- A 5-clock low glitch on an idle line → no strobes, `busy` pulses, `rxout` unchanged.
- Byte 0x3C with the stop bit forced low, then the line held low for 40 clocks → `frame_err` pulse, no `rxdone`, `rxout` keeps its previous value, `busy` stays high until the line returns high.
- `rst` asserted during DATA bit 4 of 0xFF → outputs go to reset values immediately; the next frame 0x12 is received correctly.
- With `UART_RX_PARITY_EN` defined, byte 0x07 sent with wrong parity bit 0 → `parity_err` pulse, no `rxdone`; the same byte with parity 1 → `rxdone`, `rxout` = 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and baud divider helpers.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

    // Clocks per oversample tick; never below one.
    function automatic int uart_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, restarted by clr.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          tick_r;

    // Next count: restart on clr, wrap at the terminal value.
    always_comb begin
        cnt_s = cnt_r;
        if (clr) begin
            cnt_s = {CW{1'b0}};
        end else if (cnt_r == LAST) begin
            cnt_s = {CW{1'b0}};
        end else begin
            cnt_s = cnt_r + CW'(1);
        end
    end

    // Counter and registered tick, high in the cycle the count sits at its terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            tick_r <= (cnt_s == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 2-of-3 mid-bit voting, 8N1 by default.
// Defining UART_RX_PARITY_EN switches to 8E1 and adds the parity_err strobe.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 1_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] rxout,
    output logic                   rxdone,
    output logic                   frame_err,
    output logic                   busy
`ifdef UART_RX_PARITY_EN
   ,output logic                   parity_err
`endif
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    // The start edge is already ~3 clocks old when START is entered (sync + detect),
    // so the bit counter is preloaded to keep the votes centred on the line.
    localparam int ENTRY = ((3 / DIV) < (OVERSAMPLE / 2 - 2)) ? (3 / DIV) : (OVERSAMPLE / 2 - 2);

    localparam logic [TW-1:0] T_ENTRY = TW'(ENTRY);
    localparam logic [TW-1:0] T_S0    = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_VOTE  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);

    logic                   sync_meta;
    logic                   rx_s;
    logic                   tick;
    uart_state_e            state_r, next_state_s;
    logic [TW-1:0]          tcnt_r, tcnt_s;
    logic                   samp0_r, samp0_s;
    logic                   samp1_r, samp1_s;
    logic [UART_DATA_W-1:0] shreg_r, shreg_s;
    logic [UART_DATA_W-1:0] rxout_r, rxout_s;
    logic [2:0]             bitcnt_r, bitcnt_s;
    logic                   rxdone_r, rxdone_s;
    logic                   frame_err_r, frame_err_s;
    logic                   busy_r, busy_s;
    logic                   mid_vote_s, end_bit_s, vote_s;
`ifdef UART_RX_PARITY_EN
    logic                   perr_flag_r, perr_flag_s;
    logic                   parity_err_r, parity_err_s;
`endif

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            sync_meta <= rx;
            rx_s      <= sync_meta;
        end
    end

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_r == IDLE),
        .tick (tick)
    );

    assign mid_vote_s = tick && (tcnt_r == T_VOTE);
    assign end_bit_s  = tick && (tcnt_r == T_LAST);
    assign vote_s     = majority3(samp0_r, samp1_r, rx_s);

    // Next-state, bit timing, sampling and strobe decode.
    always_comb begin
        next_state_s = state_r;
        tcnt_s       = tcnt_r;
        samp0_s      = samp0_r;
        samp1_s      = samp1_r;
        shreg_s      = shreg_r;
        bitcnt_s     = bitcnt_r;
        rxout_s      = rxout_r;
        rxdone_s     = 1'b0;
        frame_err_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_flag_s  = perr_flag_r;
        parity_err_s = 1'b0;
`endif

        if (tick && (state_r != IDLE) && (state_r != BREAK)) begin
            if (tcnt_r == T_LAST) tcnt_s = {TW{1'b0}};
            else                  tcnt_s = tcnt_r + TW'(1);
            if (tcnt_r == T_S0)   samp0_s = rx_s;
            else                  samp0_s = samp0_r;
            if (tcnt_r == T_S1)   samp1_s = rx_s;
            else                  samp1_s = samp1_r;
        end else begin
            tcnt_s = tcnt_r;
        end

        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    next_state_s = START;
                    tcnt_s       = T_ENTRY;
                    bitcnt_s     = 3'd0;
`ifdef UART_RX_PARITY_EN
                    perr_flag_s  = 1'b0;
`endif
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: begin
                if (mid_vote_s && vote_s) next_state_s = IDLE;
                else if (end_bit_s)       next_state_s = DATA;
                else                      next_state_s = START;
            end
            DATA: begin
                if (mid_vote_s) shreg_s = {vote_s, shreg_r[UART_DATA_W-1:1]};
                else            shreg_s = shreg_r;
                if (end_bit_s) begin
                    if (bitcnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        next_state_s = PARITY;
`else
                        next_state_s = STOP;
`endif
                    end else begin
                        bitcnt_s = bitcnt_r + 3'd1;
                    end
                end else begin
                    next_state_s = DATA;
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (mid_vote_s) perr_flag_s = vote_s ^ even_parity(shreg_r);
                else            perr_flag_s = perr_flag_r;
                if (end_bit_s)  next_state_s = STOP;
                else            next_state_s = PARITY;
`else
                next_state_s = IDLE;
`endif
            end
            STOP: begin
                if (mid_vote_s) begin
                    if (vote_s) begin
                        next_state_s = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (perr_flag_r) begin
                            parity_err_s = 1'b1;
                        end else begin
                            rxout_s  = shreg_r;
                            rxdone_s = 1'b1;
                        end
`else
                        rxout_s  = shreg_r;
                        rxdone_s = 1'b1;
`endif
                    end else begin
                        frame_err_s  = 1'b1;
                        next_state_s = BREAK;
                    end
                end else begin
                    next_state_s = STOP;
                end
            end
            BREAK: begin
                if (rx_s) next_state_s = IDLE;
                else      next_state_s = BREAK;
            end
            default: next_state_s = IDLE;
        endcase

        busy_s = (next_state_s != IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            tcnt_r       <= {TW{1'b0}};
            samp0_r      <= 1'b1;
            samp1_r      <= 1'b1;
            shreg_r      <= 8'h00;
            bitcnt_r     <= 3'd0;
            rxout_r      <= 8'h00;
            rxdone_r     <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_flag_r  <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r      <= next_state_s;
            tcnt_r       <= tcnt_s;
            samp0_r      <= samp0_s;
            samp1_r      <= samp1_s;
            shreg_r      <= shreg_s;
            bitcnt_r     <= bitcnt_s;
            rxout_r      <= rxout_s;
            rxdone_r     <= rxdone_s;
            frame_err_r  <= frame_err_s;
            busy_r       <= busy_s;
`ifdef UART_RX_PARITY_EN
            perr_flag_r  <= perr_flag_s;
            parity_err_r <= parity_err_s;
`endif
        end
    end

    assign rxout     = rxout_r;
    assign rxdone    = rxdone_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os at DIV = 1 (16 clocks per bit); honours UART_RX_PARITY_EN.
module tb_uart_rx_os;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 62_500;
    localparam int OS       = 16;
    localparam int BITLEN   = 16;
`ifdef UART_RX_PARITY_EN
    localparam int EXP_LAT  = 155 + BITLEN;
`else
    localparam int EXP_LAT  = 155;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rxout;
    logic       rxdone;
    logic       frame_err;
    logic       busy;
    logic       parity_err;

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    uart_rx_os #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rxout      (rxout),
        .rxdone     (rxdone),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef UART_RX_PARITY_EN
       ,.parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         exp_done = 0;
    int         last_done_cyc = 0;
    int         fall_cyc = 0;
    bit         busy_seen = 1'b0;
    logic [7:0] last_good = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every rxdone.
    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (rxdone || frame_err || parity_err)
            check_eq("strobe_onehot", 32'(rxdone) + 32'(frame_err) + 32'(parity_err), 32'd1);
        if (rxdone) begin
            done_cnt++;
            last_done_cyc = cyc;
            check_eq("rxdone_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check_eq("rxout", {24'd0, rxout}, {24'd0, exp_q.pop_front()});
        end
        if (frame_err)  ferr_cnt++;
        if (parity_err) perr_cnt++;
    end

    task automatic send_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_len, input logic stop_v);
        fall_cyc = cyc;
        send_bit(1'b0, BITLEN);
        for (int i = 0; i < 8; i++) send_bit(d[i], BITLEN);
`ifdef UART_RX_PARITY_EN
        send_bit(^d, BITLEN);
`endif
        send_bit(stop_v, stop_len);
    endtask

    task automatic expect_byte(input logic [7:0] d);
        exp_q.push_back(d);
        exp_done++;
        last_good = d;
    endtask

    initial begin
        int lat;
        int base_done;
        int base_ferr;
        logic [7:0] b;

        rx  = 1'b1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_rxout", {24'd0, rxout}, 32'h0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_rxdone", {31'd0, rxdone}, 32'd0);
        check_eq("reset_frame_err", {31'd0, frame_err}, 32'd0);
        repeat (5) @(posedge clk);
        #1;

        // Single byte and completion latency
        expect_byte(8'hA5);
        send_frame(8'hA5, BITLEN, 1'b1);
        send_bit(1'b1, 10);
        lat = last_done_cyc - fall_cyc;
        check_eq("latency_pm1", (lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1) ? EXP_LAT : lat, EXP_LAT);
        check_eq("a5_done_cnt", done_cnt, exp_done);
        check_eq("a5_no_ferr", ferr_cnt, 32'd0);
        check_eq("a5_no_perr", perr_cnt, 32'd0);

        // Back-to-back frames with half-length stop bits
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(200, 10));
            expect_byte(b);
            send_frame(b, BITLEN / 2, 1'b1);
        end
        send_bit(1'b1, 30);
        check_eq("b2b_done_cnt", done_cnt, exp_done);
        check_eq("b2b_queue_empty", exp_q.size(), 32'd0);

        // Short glitch on idle line
        base_done = done_cnt;
        base_ferr = ferr_cnt;
        busy_seen = 1'b0;
        send_bit(1'b0, 5);
        send_bit(1'b1, 40);
        check_eq("glitch_busy_pulsed", {31'd0, busy_seen}, 32'd1);
        check_eq("glitch_no_done", done_cnt, base_done);
        check_eq("glitch_no_ferr", ferr_cnt, base_ferr);
        check_eq("glitch_rxout_held", {24'd0, rxout}, {24'd0, last_good});
        check_eq("glitch_busy_low", {31'd0, busy}, 32'd0);

        // Low stop bit followed by a held-low line
        send_frame(8'h3C, BITLEN, 1'b0);
        send_bit(1'b0, 40);
        @(negedge clk);
        check_eq("break_busy_high", {31'd0, busy}, 32'd1);
        check_eq("ferr_cnt", ferr_cnt, base_ferr + 1);
        check_eq("ferr_no_done", done_cnt, base_done);
        check_eq("ferr_rxout_held", {24'd0, rxout}, {24'd0, last_good});
        @(posedge clk);
        #1;
        send_bit(1'b1, 10);
        check_eq("break_released", {31'd0, busy}, 32'd0);

        // Reset in the middle of data bit 4 of 0xFF
        base_ferr = ferr_cnt;
        send_bit(1'b0, BITLEN);
        send_bit(1'b1, BITLEN * 4 + BITLEN / 2);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check_eq("midrst_rxout", {24'd0, rxout}, 32'h0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        last_good = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        send_bit(1'b1, 40);
        check_eq("midrst_no_done", done_cnt, exp_done);
        check_eq("midrst_no_ferr", ferr_cnt, base_ferr);
        expect_byte(8'h12);
        send_frame(8'h12, BITLEN, 1'b1);
        send_bit(1'b1, 10);
        check_eq("after_rst_done", done_cnt, exp_done);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit must be 1
        send_bit(1'b0, BITLEN);
        for (int i = 0; i < 8; i++) send_bit(((8'h07 >> i) & 8'h01) != 8'h00, BITLEN);
        send_bit(1'b0, BITLEN);
        send_bit(1'b1, BITLEN);
        send_bit(1'b1, 10);
        check_eq("perr_cnt", perr_cnt, 32'd1);
        check_eq("perr_no_done", done_cnt, exp_done);
        check_eq("perr_rxout_held", {24'd0, rxout}, {24'd0, last_good});
        expect_byte(8'h07);
        send_frame(8'h07, BITLEN, 1'b1);
        send_bit(1'b1, 10);
        check_eq("par_ok_done", done_cnt, exp_done);
        check_eq("par_ok_perr", perr_cnt, 32'd1);
`else
        check_eq("no_perr", perr_cnt, 32'd0);
`endif

        check_eq("final_queue_empty", exp_q.size(), 32'd0);
        check_eq("final_done_total", done_cnt, exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
